// File: rtl/fb_scanout_reader_if.sv
// Framebuffer access bundle: read port for scanout and clear-write port on the RAM's second port.
interface fb_scanout_reader_if #(
    parameter int unsigned ADDR_WIDTH = 19
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_data;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_data;

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/fb_scanout_reader.sv
// Scans a 1-bpp framebuffer out in raster order with VGA timing, latency-aligned outputs
// and optional clear-after-read.
module fb_scanout_reader #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter int unsigned ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_en,
    input  logic                clear_en,
    fb_scanout_reader_if.master fb,
    output logic                pixel,
    output logic                hsync,
    output logic                vsync,
    output logic                active,
    output logic                frame_done
);
    localparam int unsigned H_TOTAL = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    // Compare limits are one bit wider so a sync end equal to the total cannot wrap.
    localparam logic [HW:0]   H_VIS      = (HW+1)'(SCREEN_WIDTH);
    localparam logic [HW:0]   HS_START   = (HW+1)'(SCREEN_WIDTH + H_FRONT);
    localparam logic [HW:0]   HS_END     = (HW+1)'(SCREEN_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VW:0]   V_VIS      = (VW+1)'(SCREEN_HEIGHT);
    localparam logic [VW:0]   VS_START   = (VW+1)'(SCREEN_HEIGHT + V_FRONT);
    localparam logic [VW:0]   VS_END     = (VW+1)'(SCREEN_HEIGHT + V_FRONT + V_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_LAST = VW'(SCREEN_HEIGHT - 1);

    typedef struct packed {
        logic                  tick;
        logic                  vis;
        logic                  hs;
        logic                  vs;
        logic                  clr;
        logic [ADDR_WIDTH-1:0] addr;
    } sb_t;

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  clr_frame;

    logic [HW:0] h_ext;
    logic [VW:0] v_ext;
    logic        vis_now;
    logic        hs_now;
    logic        vs_now;
    logic        frame_start;
    logic        h_wrap;
    logic        v_wrap;
    logic        clr_now;
    sb_t         sb_in;
    sb_t         sb [0:READ_LATENCY];
    sb_t         sb_out;

    always_comb begin
        h_ext       = {1'b0, h_cnt};
        v_ext       = {1'b0, v_cnt};
        vis_now     = (h_ext < H_VIS) && (v_ext < V_VIS);
        hs_now      = !((h_ext >= HS_START) && (h_ext < HS_END));
        vs_now      = !((v_ext >= VS_START) && (v_ext < VS_END));
        frame_start = (h_cnt == '0) && (v_cnt == '0);
        h_wrap      = (h_cnt == H_LAST);
        v_wrap      = (v_cnt == V_LAST);
        // The first read of a frame must already see the freshly latched clear request.
        clr_now     = frame_start ? clear_en : clr_frame;

        sb_in.tick  = pix_en;
        sb_in.vis   = vis_now;
        sb_in.hs    = hs_now;
        sb_in.vs    = vs_now;
        sb_in.clr   = clr_now;
        sb_in.addr  = addr_cnt;

        sb_out      = sb[READ_LATENCY];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            addr_cnt  <= '0;
            clr_frame <= 1'b0;
        end else if (pix_en) begin
            if (frame_start) clr_frame <= clear_en;
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            if (h_wrap && v_wrap) addr_cnt <= '0;
            else if (vis_now)     addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fb.rd_en   <= 1'b0;
            fb.rd_addr <= '0;
            frame_done <= 1'b0;
        end else begin
            fb.rd_en   <= pix_en && vis_now;
            frame_done <= pix_en && h_wrap && (v_cnt == V_VIS_LAST);
            if (pix_en && vis_now)              fb.rd_addr <= addr_cnt;
            else if (pix_en && h_wrap && v_wrap) fb.rd_addr <= '0;
        end
    end

    // Sideband delay line: the last stage lines up with rd_data for the read issued at load time.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i <= READ_LATENCY; i++) sb[i] <= '0;
        end else begin
            sb[0] <= sb_in;
            for (int unsigned i = 1; i <= READ_LATENCY; i++) sb[i] <= sb[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel  <= 1'b0;
            active <= 1'b0;
            hsync  <= 1'b1;
            vsync  <= 1'b1;
        end else if (sb_out.tick) begin
            pixel  <= sb_out.vis & fb.rd_data;
            active <= sb_out.vis;
            hsync  <= sb_out.hs;
            vsync  <= sb_out.vs;
        end
    end

    // Clear write retires on the same edge that captures the read data for that address.
    always_comb begin
        fb.wr_valid = sb_out.tick & sb_out.vis & sb_out.clr;
        fb.wr_addr  = sb_out.addr;
        fb.wr_data  = 1'b0;
    end
endmodule

// File: tb/tb_fb_scanout_reader.sv
// Self-checking bench for fb_scanout_reader: small raster, synchronous RAM model and a
// tick-position reference model with scheduled expectations.
module tb_fb_scanout_reader;
    localparam int unsigned W    = 8;
    localparam int unsigned H    = 4;
    localparam int unsigned HF   = 1;
    localparam int unsigned HS   = 2;
    localparam int unsigned HB   = 1;
    localparam int unsigned VF   = 1;
    localparam int unsigned VS   = 1;
    localparam int unsigned VB   = 1;
    localparam int unsigned AW   = 5;
    localparam int unsigned HT   = W + HF + HS + HB;
    localparam int unsigned VT   = H + VF + VS + VB;
    localparam int unsigned FT   = HT * VT;
    localparam int unsigned NPIX = W * H;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;
    logic clear_en;
    logic pixel, hsync, vsync, active, frame_done;

    fb_scanout_reader_if #(.ADDR_WIDTH(AW)) fb ();

    fb_scanout_reader #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .H_FRONT      (HF),
        .H_SYNC       (HS),
        .H_BACK       (HB),
        .V_FRONT      (VF),
        .V_SYNC       (VS),
        .V_BACK       (VB),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .clear_en  (clear_en),
        .fb        (fb),
        .pixel     (pixel),
        .hsync     (hsync),
        .vsync     (vsync),
        .active    (active),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous single-cycle-latency RAM with a bulk-load hook.
    logic ram      [NPIX];
    logic load_img [NPIX];
    logic load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < int'(NPIX); i++) ram[i] <= load_img[i];
        end else if (fb.wr_valid) begin
            ram[fb.wr_addr] <= fb.wr_data;
        end
        if (fb.rd_en) fb.rd_data <= ram[fb.rd_addr];
    end

    // Reference model state.
    int unsigned mt;
    int unsigned cyc;
    logic        clrm;
    logic        ref_img [NPIX];
    logic        e_pix, e_act, e_hs, e_vs;
    logic        s_out [8];
    logic        s_pix [8];
    logic        s_act [8];
    logic        s_hs  [8];
    logic        s_vs  [8];
    logic        s_wr  [8];
    int unsigned s_wa  [8];

    int n_cmp;
    int n_fail;
    int unsigned rd_cnt, wr_cnt, fd_cnt, ones_cnt;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic pe, input logic ce, input logic r);
        int unsigned h, v, a;
        int unsigned e_ra, e_wa;
        logic        vis, e_rd, e_fd, e_wr;
        pix_en   = pe;
        clear_en = ce;
        reset    = r;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e_rd = 1'b0; e_fd = 1'b0; e_wr = 1'b0; e_ra = 0; e_wa = 0;
        if (r) begin
            mt   = 0;
            clrm = 1'b0;
            for (int i = 0; i < 8; i++) begin
                s_out[i] = 1'b0;
                s_wr[i]  = 1'b0;
            end
            e_pix = 1'b0; e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
        end else begin
            if (pe) begin
                h = mt % HT;
                v = (mt / HT) % VT;
                if (h == 0 && v == 0) clrm = ce;
                vis = (h < W) && (v < H);
                a   = v * W + h;
                s_out[(cyc + 2) % 8] = 1'b1;
                s_pix[(cyc + 2) % 8] = 1'b0;
                if (vis) begin
                    e_rd = 1'b1;
                    e_ra = a;
                    s_pix[(cyc + 2) % 8] = ref_img[a];
                    if (clrm) begin
                        s_wr[(cyc + 1) % 8] = 1'b1;
                        s_wa[(cyc + 1) % 8] = a;
                        ref_img[a] = 1'b0;
                    end
                end
                s_act[(cyc + 2) % 8] = vis;
                s_hs[(cyc + 2) % 8]  = !(h >= W + HF && h < W + HF + HS);
                s_vs[(cyc + 2) % 8]  = !(v >= H + VF && v < H + VF + VS);
                e_fd = (h == HT - 1) && (v == H - 1);
                mt++;
            end
            if (s_out[cyc % 8]) begin
                e_pix = s_pix[cyc % 8];
                e_act = s_act[cyc % 8];
                e_hs  = s_hs[cyc % 8];
                e_vs  = s_vs[cyc % 8];
                s_out[cyc % 8] = 1'b0;
            end
            if (s_wr[cyc % 8]) begin
                e_wr = 1'b1;
                e_wa = s_wa[cyc % 8];
                s_wr[cyc % 8] = 1'b0;
            end
        end

        if (r) chk("reset_rd_addr", 32'(fb.rd_addr), 0);
        chk("rd_en", 32'(fb.rd_en), 32'(e_rd));
        if (e_rd) chk("rd_addr", 32'(fb.rd_addr), e_ra);
        chk("wr_valid", 32'(fb.wr_valid), 32'(e_wr));
        if (e_wr) begin
            chk("wr_addr", 32'(fb.wr_addr), e_wa);
            chk("wr_data", 32'(fb.wr_data), 0);
        end
        chk("pixel", 32'(pixel), 32'(e_pix));
        chk("active", 32'(active), 32'(e_act));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("frame_done", 32'(frame_done), 32'(e_fd));

        if (fb.rd_en)    rd_cnt++;
        if (fb.wr_valid) wr_cnt++;
        if (frame_done)  fd_cnt++;
        if (pixel)       ones_cnt++;
    endtask

    task automatic load(input bit random_img);
        for (int i = 0; i < int'(NPIX); i++) begin
            if (random_img) load_img[i] = 1'($urandom_range(0, 1));
            else            load_img[i] = (i % (W + 1) == 0) && (i / int'(W) < int'(H));
            ref_img[i] = load_img[i];
        end
        load_req = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        load_req = 1'b0;
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; fd_cnt = 0; ones_cnt = 0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; mt = 0; clrm = 1'b0;
        e_pix = 1'b0; e_act = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_out[i] = 1'b0; s_wr[i] = 1'b0;
        end
        reset = 1'b1; pix_en = 1'b0; clear_en = 1'b0;
        clear_counts();

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b1);

        // Continuous ticks, diagonal image: two frames
        load(1'b0);
        clear_counts();
        repeat (2 * FT) step(1'b1, 1'b0, 1'b0);
        chk("cont_reads", rd_cnt, 2 * NPIX);
        chk("cont_frame_done", fd_cnt, 2);
        chk("cont_ones", ones_cnt, 8);
        chk("cont_no_writes", wr_cnt, 0);

        // Clear frame, then a frame that must read all zeros
        clear_counts();
        repeat (FT) step(1'b1, 1'b1, 1'b0);
        chk("clear_writes", wr_cnt, NPIX);
        chk("clear_ones", ones_cnt, 4);
        clear_counts();
        repeat (FT) step(1'b1, 1'b0, 1'b0);
        chk("after_clear_ones", ones_cnt, 0);
        chk("after_clear_writes", wr_cnt, 0);

        // Random image, clear_en raised at v=2: only the following frame clears
        load(1'b1);
        clear_counts();
        repeat (2 * HT) step(1'b1, 1'b0, 1'b0);
        repeat (FT - 2 * HT) step(1'b1, 1'b1, 1'b0);
        chk("midframe_no_writes", wr_cnt, 0);
        clear_counts();
        repeat (HT) step(1'b1, 1'b1, 1'b0);
        repeat (FT - HT) step(1'b1, 1'b0, 1'b0);
        chk("nextframe_writes", wr_cnt, NPIX);
        clear_counts();
        repeat (FT) step(1'b1, 1'b0, 1'b0);
        chk("cleared_frame_ones", ones_cnt, 0);

        // Sparse ticks: pix_en every second clk for two frames
        load(1'b1);
        clear_counts();
        repeat (2 * FT) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("sparse_frame_done", fd_cnt, 2);
        chk("sparse_reads", rd_cnt, 2 * NPIX);

        // Random tick pattern with random clear requests
        repeat (3 * FT) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

        // Reset at h=5, v=2 with diagonal image, then restart from the origin
        repeat (8) step(1'b0, 1'b0, 1'b1);
        load(1'b0);
        for (int k = 0; k < 2 * int'(FT) && mt != 2 * HT + 5; k++) step(1'b1, 1'b0, 1'b0);
        chk("reset_position_reached", mt, 2 * HT + 5);
        repeat (2) step(1'b1, 1'b0, 1'b1);
        clear_counts();
        repeat (FT) step(1'b1, 1'b0, 1'b0);
        chk("post_reset_reads", rd_cnt, NPIX);
        chk("post_reset_ones", ones_cnt, 4);
        chk("post_reset_frame_done", fd_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
